ll_keyentry: RTL and testbench
==============================

# ll_keyentry

Multi-channel BCD keypad entry register for the lunar lander. It sits downstream of `keysync` and is clocked by the synchronised key strobe. Digit keys build a pending BCD number in an entry buffer, and W/X/Y/Z keys commit, backspace, clear or change the target channel. Committed values drive the lander's settable quantities (thrust, fuel load, start altitude, ...) through a flattened output bus and a commit toggle that faster domains can edge-detect.

## Interface
Parameters:
- `NCH`, 4: number of target channels; must be ≥2.
- `DIGITS`, 4: BCD digits per channel and in the entry buffer; must be ≥2.
- `INIT`, 16'h0005: reset value of every channel, DIGITS*4 bits, valid BCD.
- `MAXV`, 16'h9999: saturation limit for committed values, DIGITS*4 bits, valid BCD.

Ports:
- `keyclk` in 1: key strobe clock; one rising edge per key press.
- `reset` in 1: asynchronous, active-high.
- `keyout` in 5: key code from `keysync`, stable at the rising edge of `keyclk`.
- `sel` out $clog2(NCH): currently selected channel.
- `values` out NCH*DIGITS*4: committed channel values; channel i occupies bits [i*DIGITS*4 +: DIGITS*4].
- `entry` out DIGITS*4: pending entry buffer, with the newest digit in bits [3:0].
- `count` out $clog2(DIGITS+1): number of digits in the buffer.
- `editing` out 1: high when the buffer is non-empty (state EDIT).
- `commit_tgl` out 1: toggles on every accepted commit.
- `sat` out 1: high when the last commit was clamped to MAXV.
- `err` out 1: high when the last key was rejected.

## Operation
- Key decode: 0–9 are digits, 10–15 are invalid, 16 (W) commits, 17 (X) is backspace, 18 (Y) clears, 19 (Z) selects the next channel.
- State machine with two states:
  - IDLE: count=0.
  - EDIT: count>0.
- Digit in either state with count<DIGITS: entry={entry[DIGITS*4-5:0],d}, count+1, go to EDIT.
- Digit with count==DIGITS: rejected (see Configuration).
- Commit in EDIT:
  - values[sel] = min(entry, MAXV), comparing as unsigned binary, which is order-preserving for valid BCD.
  - sat = (entry>MAXV).
  - commit_tgl toggles.
  - entry=0, count=0, go to IDLE.
- Backspace in EDIT: entry=entry>>4 with zero fill at the top, count−1. Go to IDLE when count reaches 0.
- Clear in EDIT: entry=0, count=0, go to IDLE. Channel values are unchanged.
- Select in either state: sel=(sel==NCH-1)?0:sel+1. Any pending entry is discarded (entry=0, count=0, go to IDLE).
- Rejected keys: digits 10–15, commit in IDLE, backspace in IDLE, clear in IDLE, and a digit when the buffer is full without the macro.
  - A rejected key sets err=1 and changes nothing else.
  - Any accepted key clears err.
- `sat` changes only on commits.

## Timing
- All state is updated on the rising edge of `keyclk`; all outputs are registered, with no combinational path from `keyout` to any output.
- Latency is one `keyclk` edge: a commit is visible on `values` and `commit_tgl` immediately after the committing edge.
- Reset is asynchronous at any time, including mid-entry. It sets:
  - every channel of `values` to INIT;
  - entry=0, count=0, editing=0;
  - sel=0;
  - commit_tgl=0, sat=0, err=0.
- Consumers in `hz100` sample `commit_tgl` through a 2-flop synchroniser. `values` is stable from the commit edge until the next key press, which is at least 2 `hz100` cycles away because of `keysync`.

## Configuration
- `LL_KEYENTRY_AUTOCOMMIT_EN`:
  - Defined: a digit that brings count to DIGITS also commits in the same edge. values[sel] gets the clamped new buffer, commit_tgl toggles, and the block returns to IDLE, so count never reads DIGITS.
  - Undefined: the buffer holds DIGITS digits until W, X, Y or Z. Further digits are rejected (err=1).

## Test plan
- Reset, then no keys: values={4{16'h0005}}, sel=0, editing=0, err=0, commit_tgl=0.
- Keys 1,2,W: entry goes 0001→0012, count 1→2. After W, values[0]=16'h0012, commit_tgl=1, editing=0, sat=0.
- MAXV=16'h0500, keys 9,9,9,W: values[0]=16'h0500 and sat=1. A following 3,W gives 16'h0003 with sat=0.
- Keys 4,5,X,W: after X, entry=16'h0004 and count=1. After W, values[0]=16'h0004. A following X in IDLE gives err=1 with nothing else changed.
- Z×4: sel steps 1,2,3,0. Keys 7,Z: the buffer is discarded, sel=1, and values are unchanged. Key 11 gives err=1, and the next digit clears err.
- Keys 1,2,3,4,5: with the macro, values[0]=16'h1234 after the 4th key and the 5th key starts a new entry 16'h0005. Without the macro, the 5th key gives err=1 and entry stays 16'h1234. Asserting reset with count=2 returns all outputs to their reset values.

Source files
------------

// File: rtl/ll_keyentry.sv
// ============================================================================
// Module   : ll_keyentry
// Purpose  : Multi-channel BCD keypad entry register. Digit keys fill a
//            pending buffer; W/X/Y/Z commit, backspace, clear, select channel.
//            Optional macro LL_KEYENTRY_AUTOCOMMIT_EN commits on a full buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ll_keyentry #(
   parameter int                    NCH    = 4,
   parameter int                    DIGITS = 4,
   parameter logic [DIGITS*4-1:0]   INIT   = 16'h0005,
   parameter logic [DIGITS*4-1:0]   MAXV   = 16'h9999
) (
   input  logic                          keyclk,
   input  logic                          reset,
   input  logic [4:0]                    keyout,
   output logic [$clog2(NCH)-1:0]        sel,
   output logic [NCH*DIGITS*4-1:0]       values,
   output logic [DIGITS*4-1:0]           entry,
   output logic [$clog2(DIGITS+1)-1:0]   count,
   output logic                          editing,
   output logic                          commit_tgl,
   output logic                          sat,
   output logic                          err
);

   localparam int DW   = DIGITS * 4;
   localparam int SELW = $clog2(NCH);
   localparam int CNTW = $clog2(DIGITS + 1);

   localparam logic [4:0]      C_KEY_W    = 5'd16;
   localparam logic [4:0]      C_KEY_X    = 5'd17;
   localparam logic [4:0]      C_KEY_Y    = 5'd18;
   localparam logic [4:0]      C_KEY_Z    = 5'd19;
   localparam logic [CNTW-1:0] C_DIGITS   = CNTW'(DIGITS);
   localparam logic [CNTW-1:0] C_ONE      = CNTW'(1);
   localparam logic [SELW-1:0] C_SEL_LAST = SELW'(NCH - 1);
`ifdef LL_KEYENTRY_AUTOCOMMIT_EN
   localparam logic [CNTW-1:0] C_LAST     = CNTW'(DIGITS - 1);
`endif

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_EDIT = 1'b1
   } state_t;

   state_t          r_state, w_state_n;
   logic [SELW-1:0] r_sel, w_sel_n;
   logic [DW-1:0]   r_entry, w_entry_n;
   logic [CNTW-1:0] r_count, w_count_n;
   logic            r_tgl, r_sat, r_err, w_err_n;
   logic            w_commit;
   logic [DW-1:0]   w_commit_src, w_commit_val, w_shift;
   logic            w_commit_sat;

   assign w_shift      = {r_entry[DW-5:0], keyout[3:0]};
   // Unsigned binary compare is order-preserving for valid BCD.
   assign w_commit_sat = (w_commit_src > MAXV);
   assign w_commit_val = w_commit_sat ? MAXV : w_commit_src;

   always_comb begin
      w_state_n    = r_state;
      w_sel_n      = r_sel;
      w_entry_n    = r_entry;
      w_count_n    = r_count;
      w_err_n      = 1'b0;
      w_commit     = 1'b0;
      w_commit_src = r_entry;
      if (keyout < 5'd10) begin
         if (r_count < C_DIGITS) begin
`ifdef LL_KEYENTRY_AUTOCOMMIT_EN
            if (r_count == C_LAST) begin
               w_commit     = 1'b1;
               w_commit_src = w_shift;
               w_entry_n    = '0;
               w_count_n    = '0;
               w_state_n    = S_IDLE;
            end else
`endif
            begin
               w_entry_n = w_shift;
               w_count_n = r_count + 1'b1;
               w_state_n = S_EDIT;
            end
         end else begin
            w_err_n = 1'b1;
         end
      end else begin
         case (keyout)
            C_KEY_W: begin
               if (r_state == S_EDIT) begin
                  w_commit  = 1'b1;
                  w_entry_n = '0;
                  w_count_n = '0;
                  w_state_n = S_IDLE;
               end else begin
                  w_err_n = 1'b1;
               end
            end
            C_KEY_X: begin
               if (r_state == S_EDIT) begin
                  w_entry_n = r_entry >> 4;
                  w_count_n = r_count - 1'b1;
                  if (r_count == C_ONE) w_state_n = S_IDLE;
               end else begin
                  w_err_n = 1'b1;
               end
            end
            C_KEY_Y: begin
               if (r_state == S_EDIT) begin
                  w_entry_n = '0;
                  w_count_n = '0;
                  w_state_n = S_IDLE;
               end else begin
                  w_err_n = 1'b1;
               end
            end
            C_KEY_Z: begin
               w_sel_n   = (r_sel == C_SEL_LAST) ? '0 : r_sel + 1'b1;
               w_entry_n = '0;
               w_count_n = '0;
               w_state_n = S_IDLE;
            end
            default: w_err_n = 1'b1;
         endcase
      end
   end

   always_ff @(posedge keyclk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_sel   <= '0;
         r_entry <= '0;
         r_count <= '0;
         r_tgl   <= 1'b0;
         r_sat   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_sel   <= w_sel_n;
         r_entry <= w_entry_n;
         r_count <= w_count_n;
         r_err   <= w_err_n;
         if (w_commit) begin
            r_tgl <= ~r_tgl;
            r_sat <= w_commit_sat;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_chan
         logic [DW-1:0] r_val;
         always_ff @(posedge keyclk or posedge reset) begin
            if (reset)
               r_val <= INIT;
            else if (w_commit && (r_sel == SELW'(gi)))
               r_val <= w_commit_val;
         end
         assign values[gi*DW +: DW] = r_val;
      end
   endgenerate

   assign sel        = r_sel;
   assign entry      = r_entry;
   assign count      = r_count;
   assign editing    = (r_state == S_EDIT);
   assign commit_tgl = r_tgl;
   assign sat        = r_sat;
   assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ll_keyentry.sv
// ============================================================================
// Module   : tb_ll_keyentry
// Purpose  : Self-checking bench for ll_keyentry (default and MAXV=0500).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ll_keyentry;

   logic        keyclk;
   logic        reset;
   logic        reset2;
   logic [4:0]  keyout;

   logic [1:0]  sel, sel2;
   logic [63:0] values, values2;
   logic [15:0] entry, entry2;
   logic [2:0]  count, count2;
   logic        editing, editing2, commit_tgl, commit_tgl2, sat, sat2, err, err2;

   ll_keyentry dut (
      .keyclk(keyclk), .reset(reset), .keyout(keyout),
      .sel(sel), .values(values), .entry(entry), .count(count),
      .editing(editing), .commit_tgl(commit_tgl), .sat(sat), .err(err)
   );

   ll_keyentry #(.MAXV(16'h0500)) dut2 (
      .keyclk(keyclk), .reset(reset2), .keyout(keyout),
      .sel(sel2), .values(values2), .entry(entry2), .count(count2),
      .editing(editing2), .commit_tgl(commit_tgl2), .sat(sat2), .err(err2)
   );

   typedef struct packed {
      logic [4:0]  key;
      logic [15:0] entry;
      logic [2:0]  count;
      logic        editing;
      logic [1:0]  sel;
      logic [63:0] values;
      logic        tgl;
      logic        sat;
      logic        err;
   } vec_t;

   vec_t tv[$];
   int   checks = 0;
   int   errors = 0;

   localparam logic [4:0]  KW = 5'd16, KX = 5'd17, KY = 5'd18, KZ = 5'd19;
   localparam logic [15:0] A  = 16'h0005;
   localparam logic [63:0] V0 = {A, A, A, A};
   localparam logic [63:0] V1 = {A, A, A, 16'h0012};
   localparam logic [63:0] V2 = {A, A, A, 16'h0004};
   localparam logic [63:0] V3 = {A, A, 16'h0098, 16'h0004};
   localparam logic [63:0] V4 = {A, 16'h1234, 16'h0098, 16'h0004};

   task automatic add(input logic [4:0] k, input logic [15:0] e, input logic [2:0] c,
                      input logic ed, input logic [1:0] s, input logic [63:0] v,
                      input logic t, input logic sa, input logic er);
      vec_t r;
      r = '{key: k, entry: e, count: c, editing: ed, sel: s, values: v,
            tgl: t, sat: sa, err: er};
      tv.push_back(r);
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic press(input logic [4:0] k);
      keyout = k;
      #5 keyclk = 1'b1;
      #5 keyclk = 1'b0;
   endtask

   function automatic vec_t observe(input logic [4:0] k);
      vec_t o;
      o = '{key: k, entry: entry, count: count, editing: editing, sel: sel,
            values: values, tgl: commit_tgl, sat: sat, err: err};
      return o;
   endfunction

   initial begin
      keyclk = 1'b0;
      keyout = 5'd10;
      reset  = 1'b0;
      reset2 = 1'b0;
      #1 reset = 1'b1; reset2 = 1'b1;
      #2 reset = 1'b0; reset2 = 1'b0;
      #2;

      chk("reset_state", 128'(observe(5'd0)),
          128'(vec_t'{key: 5'd0, entry: 16'h0, count: 3'd0, editing: 1'b0, sel: 2'd0,
                      values: V0, tgl: 1'b0, sat: 1'b0, err: 1'b0}));

      add(5'd1, 16'h0001, 3'd1, 1, 2'd0, V0, 0, 0, 0);
      add(5'd2, 16'h0012, 3'd2, 1, 2'd0, V0, 0, 0, 0);
      add(KW,   16'h0000, 3'd0, 0, 2'd0, V1, 1, 0, 0);
      add(5'd4, 16'h0004, 3'd1, 1, 2'd0, V1, 1, 0, 0);
      add(5'd5, 16'h0045, 3'd2, 1, 2'd0, V1, 1, 0, 0);
      add(KX,   16'h0004, 3'd1, 1, 2'd0, V1, 1, 0, 0);
      add(KW,   16'h0000, 3'd0, 0, 2'd0, V2, 0, 0, 0);
      add(KX,   16'h0000, 3'd0, 0, 2'd0, V2, 0, 0, 1);
      add(KZ,   16'h0000, 3'd0, 0, 2'd1, V2, 0, 0, 0);
      add(KZ,   16'h0000, 3'd0, 0, 2'd2, V2, 0, 0, 0);
      add(KZ,   16'h0000, 3'd0, 0, 2'd3, V2, 0, 0, 0);
      add(KZ,   16'h0000, 3'd0, 0, 2'd0, V2, 0, 0, 0);
      add(5'd7, 16'h0007, 3'd1, 1, 2'd0, V2, 0, 0, 0);
      add(KZ,   16'h0000, 3'd0, 0, 2'd1, V2, 0, 0, 0);
      add(5'd11,16'h0000, 3'd0, 0, 2'd1, V2, 0, 0, 1);
      add(5'd3, 16'h0003, 3'd1, 1, 2'd1, V2, 0, 0, 0);
      add(KY,   16'h0000, 3'd0, 0, 2'd1, V2, 0, 0, 0);
      add(KY,   16'h0000, 3'd0, 0, 2'd1, V2, 0, 0, 1);
      add(KW,   16'h0000, 3'd0, 0, 2'd1, V2, 0, 0, 1);
      add(5'd9, 16'h0009, 3'd1, 1, 2'd1, V2, 0, 0, 0);
      add(5'd8, 16'h0098, 3'd2, 1, 2'd1, V2, 0, 0, 0);
      add(KW,   16'h0000, 3'd0, 0, 2'd1, V3, 1, 0, 0);
      add(KZ,   16'h0000, 3'd0, 0, 2'd2, V3, 1, 0, 0);
      add(5'd6, 16'h0006, 3'd1, 1, 2'd2, V3, 1, 0, 0);
      add(KX,   16'h0000, 3'd0, 0, 2'd2, V3, 1, 0, 0);
      add(5'd1, 16'h0001, 3'd1, 1, 2'd2, V3, 1, 0, 0);
      add(5'd2, 16'h0012, 3'd2, 1, 2'd2, V3, 1, 0, 0);
      add(5'd3, 16'h0123, 3'd3, 1, 2'd2, V3, 1, 0, 0);
`ifdef LL_KEYENTRY_AUTOCOMMIT_EN
      add(5'd4, 16'h0000, 3'd0, 0, 2'd2, V4, 0, 0, 0);
      add(5'd5, 16'h0005, 3'd1, 1, 2'd2, V4, 0, 0, 0);
      add(KY,   16'h0000, 3'd0, 0, 2'd2, V4, 0, 0, 0);
`else
      add(5'd4, 16'h1234, 3'd4, 1, 2'd2, V3, 1, 0, 0);
      add(5'd5, 16'h1234, 3'd4, 1, 2'd2, V3, 1, 0, 1);
      add(KY,   16'h0000, 3'd0, 0, 2'd2, V3, 1, 0, 0);
`endif

      for (int i = 0; i < tv.size(); i++) begin
         press(tv[i].key);
         chk($sformatf("vec%0d_key%0d", i, tv[i].key), 128'(observe(tv[i].key)), 128'(tv[i]));
      end

      // Saturation on a reduced MAXV, including the exact-limit boundary.
      reset2 = 1'b1;
      #2 reset2 = 1'b0;
      chk("dut2_reset_values", 128'(values2), 128'(V0));
      press(5'd9); press(5'd9); press(5'd9); press(KW);
      chk("sat_clamp", 128'({values2[15:0], sat2, commit_tgl2}), 128'({16'h0500, 1'b1, 1'b1}));
      press(5'd3); press(KW);
      chk("sat_release", 128'({values2[15:0], sat2, commit_tgl2}), 128'({16'h0003, 1'b0, 1'b0}));
      press(5'd5); press(5'd0); press(5'd0); press(KW);
      chk("sat_exact_max", 128'({values2[15:0], sat2, commit_tgl2}), 128'({16'h0500, 1'b0, 1'b1}));
      chk("dut2_untouched_ch", 128'(values2[63:16]), 128'({A, A, A}));

      // Asynchronous reset mid-entry, with no clock edge.
      press(KY);
      press(5'd1); press(5'd2);
      chk("pre_reset_count", 128'({count, editing}), 128'({3'd2, 1'b1}));
      reset = 1'b1;
      #2;
      chk("async_reset_state", 128'(observe(5'd0)),
          128'(vec_t'{key: 5'd0, entry: 16'h0, count: 3'd0, editing: 1'b0, sel: 2'd0,
                      values: V0, tgl: 1'b0, sat: 1'b0, err: 1'b0}));
      reset = 1'b0;
      #2;
      press(5'd8);
      chk("post_reset_digit", 128'({entry, count, editing}), 128'({16'h0008, 3'd1, 1'b1}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
